// File: rtl/spi_slave.sv
// spi_slave: SPI slave with synchronized pads, latched per-frame config and a one-word tx holding buffer
module spi_slave #(
  parameter int SPI_MAX_CHAR      = 32,
  parameter int SPI_CHAR_LEN_BITS = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ss_pad_i,
  input  logic                         sclk_pad_i,
  input  logic                         mosi_pad_i,
  output logic                         miso_pad_o,
  output logic                         miso_oe_o,
  input  logic [SPI_CHAR_LEN_BITS-1:0] char_len_i,
  input  logic                         lsb_i,
  input  logic                         tx_negedge_i,
  input  logic                         rx_negedge_i,
  input  logic [SPI_MAX_CHAR-1:0]      tx_data_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  output logic [SPI_MAX_CHAR-1:0]      rx_data_o,
  output logic                         rx_valid_o,
  output logic                         underrun_o,
  output logic                         abort_o,
  output logic                         busy_o
);
  localparam int CW = $clog2(SPI_MAX_CHAR + 1);
  localparam int IW = $clog2(SPI_MAX_CHAR);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [2:0]              r_ss_s, r_sclk_s, r_mosi_s;
  logic [0:0]              r_state;
  logic [CW-1:0]           r_len, r_rx_cnt, r_tx_idx;
  logic                    r_lsb, r_txn, r_rxn;
  logic [SPI_MAX_CHAR-1:0] r_tx_sr, r_rx_sr, r_buf, r_rx_data;
  logic                    r_buf_full, r_rx_valid, r_underrun, r_abort;
  logic                    w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_shift;
  logic                    w_enter, w_leave, w_rx_edge, w_tx_edge, w_done, w_start, w_load;
  logic [CW-1:0]           w_len_cfg, w_cnt_inc;
  logic [IW-1:0]           w_rx_widx, w_tx_widx;
  logic [SPI_MAX_CHAR-1:0] w_rx_word;
  assign w_ss_fall   = r_ss_s[2] & ~r_ss_s[1];
  assign w_ss_rise   = ~r_ss_s[2] & r_ss_s[1];
  assign w_sclk_rise = ~r_sclk_s[2] & r_sclk_s[1];
  assign w_sclk_fall = r_sclk_s[2] & ~r_sclk_s[1];
  assign w_shift     = r_state == SHIFT;
  assign w_enter     = ~w_shift & w_ss_fall;
  assign w_leave     = w_shift & w_ss_rise;
  assign w_rx_edge   = w_shift & (r_rxn ? w_sclk_fall : w_sclk_rise);
  assign w_tx_edge   = w_shift & (r_txn ? w_sclk_fall : w_sclk_rise);
  assign w_cnt_inc   = r_rx_cnt + CW'(1);
  assign w_done      = w_rx_edge & (w_cnt_inc == r_len);
  assign w_start     = w_enter | (w_done & ~w_ss_rise);
  assign w_load      = tx_valid_i & ~r_buf_full;
  assign w_len_cfg   = (char_len_i == '0) ? CW'(SPI_MAX_CHAR) : CW'(char_len_i);
  // line bit k lives at word bit k (LSB first) or L-1-k (MSB first)
  assign w_rx_widx   = IW'(r_lsb ? r_rx_cnt : r_len - CW'(1) - r_rx_cnt);
  assign w_tx_widx   = IW'(r_lsb ? r_tx_idx : r_len - CW'(1) - r_tx_idx);
  always_comb begin
    w_rx_word            = r_rx_sr;
    w_rx_word[w_rx_widx] = r_mosi_s[2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ss_s     <= '0;
      r_sclk_s   <= '0;
      r_mosi_s   <= '0;
      r_state    <= IDLE;
      r_len      <= '0;
      r_lsb      <= 1'b0;
      r_txn      <= 1'b0;
      r_rxn      <= 1'b0;
      r_rx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_ss_s     <= {r_ss_s[1:0], ss_pad_i};
      r_sclk_s   <= {r_sclk_s[1:0], sclk_pad_i};
      r_mosi_s   <= {r_mosi_s[1:0], mosi_pad_i};
      r_state    <= w_enter ? SHIFT : (w_leave ? IDLE : r_state);
      if (w_enter) begin
        r_len <= w_len_cfg;
        r_lsb <= lsb_i;
        r_txn <= tx_negedge_i;
        r_rxn <= rx_negedge_i;
      end
      r_rx_cnt   <= (w_start | w_leave) ? '0 : (w_rx_edge ? w_cnt_inc : r_rx_cnt);
      // with tx and rx on the same edge the tx side already sees this cycle's sample
      r_tx_idx   <= (w_start | w_leave | w_done) ? '0 :
                    (w_tx_edge ? ((r_txn == r_rxn) ? w_cnt_inc : r_rx_cnt) : r_tx_idx);
      r_rx_sr    <= (w_start | w_leave) ? '0 : (w_rx_edge ? w_rx_word : r_rx_sr);
      if (w_done) r_rx_data <= w_rx_word;
      if (w_start) r_tx_sr <= r_buf_full ? r_buf : '0;
      r_buf_full <= w_start ? w_load : (r_buf_full | w_load);
      if (w_load) r_buf <= tx_data_i;
      r_rx_valid <= w_done;
      r_underrun <= w_start & ~r_buf_full;
      r_abort    <= w_leave & (r_rx_cnt != '0) & ~w_done;
    end
  end
  assign miso_pad_o = w_shift & r_tx_sr[w_tx_widx];
  assign miso_oe_o  = w_shift;
  assign busy_o     = w_shift;
  assign tx_ready_o = ~r_buf_full;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign underrun_o = r_underrun;
  assign abort_o    = r_abort;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bench-driven SPI master with a queue-based model of strobes, buffer and line bits
module tb_spi_slave;
  localparam int H = 8;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic        miso_pad_o, miso_oe_o, tx_ready_o, rx_valid_o, underrun_o, abort_o, busy_o;
  logic [4:0]  char_len_i = '0;
  logic        lsb_i = 1'b0, tx_negedge_i = 1'b0, rx_negedge_i = 1'b0, tx_valid_i = 1'b0;
  logic [31:0] tx_data_i = '0, rx_data_o;
  always #5 clk = ~clk;
  spi_slave #(.SPI_MAX_CHAR(32), .SPI_CHAR_LEN_BITS(5)) dut (
    .clk(clk), .reset(reset), .ss_pad_i(ss), .sclk_pad_i(sclk), .mosi_pad_i(mosi),
    .miso_pad_o(miso_pad_o), .miso_oe_o(miso_oe_o), .char_len_i(char_len_i), .lsb_i(lsb_i),
    .tx_negedge_i(tx_negedge_i), .rx_negedge_i(rx_negedge_i), .tx_data_i(tx_data_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .underrun_o(underrun_o), .abort_o(abort_o), .busy_o(busy_o)
  );
  typedef struct { int kind; logic [31:0] data; } ev_t;
  ev_t         evq[$];
  int          tests = 0, fails = 0, n_rxv = 0, n_und = 0, n_abt = 0;
  bit          m_full = 1'b0;
  logic [31:0] m_buf = '0, m_last_rx = '0, cur_tx = '0;
  logic [31:0] f_mosi[4], f_load[4], f_read[4];
  bit          f_do_load[4];
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic clkn(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_ev(input int kind, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    evq.push_back(e);
  endtask
  task automatic expect_ev(input int kind, input logic [31:0] d, input string nm);
    ev_t e;
    tests++;
    if (evq.size() == 0) begin
      fails++;
      $display("FAIL %s: strobe seen with data %h, none expected", nm, d);
    end else begin
      e = evq.pop_front();
      if (e.kind != kind || (kind == 1 && e.data !== d)) begin
        fails++;
        $display("FAIL %s: got kind %0d data %h expected kind %0d data %h", nm, kind, d, e.kind, e.data);
      end
    end
  endtask
  // model: a character start takes the buffered word, or zeros plus an underrun event
  task automatic model_start();
    if (m_full) begin
      cur_tx = m_buf;
      m_full = 1'b0;
    end else begin
      cur_tx = '0;
      push_ev(2, '0);
    end
  endtask
  task automatic load(input logic [31:0] d);
    check("tx_ready_at_load", tx_ready_o, !m_full);
    tx_data_i = d;
    tx_valid_i = 1'b1;
    clkn(1);
    tx_valid_i = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_buf = d;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    ss = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    clkn(1);
    check("reset_outputs", {miso_pad_o, miso_oe_o, busy_o, rx_valid_o, underrun_o, abort_o, tx_ready_o, rx_data_o},
          {7'b0000001, 32'h0});
    evq.delete();
    m_full = 1'b0;
    m_last_rx = '0;
    clkn(1);
    reset = 1'b0;
    clkn(H);
  endtask
  task automatic frame(input logic [4:0] lc, input bit lsb, input bit txn, input bit rxn,
                       input int nchar, input int abort_bits, input int rst_bits);
    int L, wi, nb;
    logic [31:0] rd, mask;
    logic b;
    L = (lc == 0) ? 32 : int'(lc);
    mask = 32'hFFFF_FFFF >> (32 - L);
    char_len_i = lc;
    lsb_i = lsb;
    tx_negedge_i = txn;
    rx_negedge_i = rxn;
    if (f_do_load[0]) load(f_load[0]);
    clkn(2);
    ss = 1'b0;
    model_start();
    clkn(H);
    check("busy_in_frame", busy_o, 1);
    char_len_i = 5'($urandom);
    lsb_i = ~lsb;
    tx_negedge_i = 1'($urandom);
    rx_negedge_i = 1'($urandom);
    for (int c = 0; c < nchar; c++) begin
      nb = (c == nchar - 1 && abort_bits > 0) ? abort_bits : L;
      rd = '0;
      for (int k = 0; k < nb; k++) begin
        if (rst_bits > 0 && k == rst_bits) begin
          do_reset();
          return;
        end
        wi = lsb ? k : L - 1 - k;
        b = f_mosi[c][wi];
        if (rxn) sclk = 1'b1;
        mosi = b;
        clkn(H);
        check("miso_bit", miso_pad_o, cur_tx[wi]);
        rd[wi] = miso_pad_o;
        sclk = ~rxn;
        if (k == L - 1) begin
          push_ev(1, f_mosi[c] & mask);
          m_last_rx = f_mosi[c] & mask;
          model_start();
        end
        clkn(H);
        sclk = 1'b0;
        if (k == nb / 2 && f_do_load[c+1]) load(f_load[c+1]);
      end
      f_read[c] = rd;
    end
    clkn(H);
    if (abort_bits > 0) push_ev(3, '0);
    ss = 1'b1;
    clkn(H);
    check("busy_after_frame", busy_o, 0);
    check("oe_after_frame", miso_oe_o, 0);
    check("events_pending", evq.size(), 0);
    check("rx_data_hold", rx_data_o, m_last_rx);
    check("tx_ready_after", tx_ready_o, !m_full);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid_o) begin
        n_rxv++;
        expect_ev(1, rx_data_o, "rx_valid");
      end
      if (underrun_o) begin
        n_und++;
        expect_ev(2, '0, "underrun");
      end
      if (abort_o) begin
        n_abt++;
        expect_ev(3, '0, "abort");
      end
      if (!miso_oe_o) check("miso_idle", miso_pad_o, 0);
      check("oe_vs_busy", miso_oe_o, busy_o);
    end
  end
  initial begin
    int n0, u0, a0, lc, L, ab;
    for (int i = 0; i < 4; i++) begin
      f_mosi[i] = '0;
      f_load[i] = '0;
      f_read[i] = '0;
      f_do_load[i] = 1'b0;
    end
    clkn(3);
    check("reset_state", {miso_pad_o, miso_oe_o, busy_o, rx_valid_o, underrun_o, abort_o, tx_ready_o, rx_data_o},
          {7'b0000001, 32'h0});
    reset = 1'b0;
    clkn(4);
    f_mosi[0] = 32'h3C; f_load[0] = 32'hA5; f_do_load[0] = 1'b1;
    n0 = n_rxv;
    frame(5'd8, 1'b0, 1'b1, 1'b0, 1, 0, 0);
    check("mode10_miso_word", f_read[0], 32'hA5);
    check("mode10_rx_data", rx_data_o, 32'h3C);
    check("mode10_rx_count", n_rxv - n0, 1);
    f_mosi[0] = 32'hDEADBEEF; f_load[0] = 32'h12345678;
    frame(5'd0, 1'b1, 1'b0, 1'b1, 1, 0, 0);
    check("len32_miso_word", f_read[0], 32'h12345678);
    check("len32_rx_data", rx_data_o, 32'hDEADBEEF);
    f_mosi[0] = 32'h5A; f_mosi[1] = 32'hC3;
    f_load[0] = 32'h96; f_load[1] = 32'h0F; f_load[2] = 32'h81;
    f_do_load[1] = 1'b1; f_do_load[2] = 1'b1;
    n0 = n_rxv; u0 = n_und;
    frame(5'd8, 1'b0, 1'b1, 1'b0, 2, 0, 0);
    check("two_char_miso0", f_read[0], 32'h96);
    check("two_char_miso1", f_read[1], 32'h0F);
    check("two_char_rx", rx_data_o, 32'hC3);
    check("two_char_rx_count", n_rxv - n0, 2);
    check("two_char_underruns", n_und - u0, 0);
    for (int i = 0; i < 4; i++) f_do_load[i] = 1'b0;
    f_mosi[0] = 32'h6B;
    u0 = n_und;
    frame(5'd8, 1'b1, 1'b0, 1'b0, 1, 0, 0);
    check("underrun_miso_zero", f_read[0], 32'h0);
    check("underrun_rx", rx_data_o, 32'h6B);
    check("underrun_seen", (n_und - u0) != 0, 1);
    f_mosi[0] = 32'hFF;
    a0 = n_abt;
    frame(5'd8, 1'b0, 1'b1, 1'b0, 1, 5, 0);
    check("abort_rx_unchanged", rx_data_o, 32'h6B);
    check("abort_count", n_abt - a0, 1);
    f_mosi[0] = 32'hF0; f_load[0] = 32'h55; f_do_load[0] = 1'b1;
    frame(5'd8, 1'b0, 1'b1, 1'b0, 1, 0, 3);
    f_mosi[0] = 32'hA7; f_load[0] = 32'h3E;
    frame(5'd8, 1'b0, 1'b0, 1'b0, 1, 0, 0);
    check("post_reset_miso", f_read[0], 32'h3E);
    check("post_reset_rx", rx_data_o, 32'hA7);
    repeat (25) begin
      lc = $urandom_range(0, 31);
      L = (lc == 0) ? 32 : lc;
      for (int i = 0; i < 4; i++) begin
        f_mosi[i] = $urandom;
        f_load[i] = $urandom;
        f_do_load[i] = 1'($urandom_range(0, 1));
      end
      ab = (L > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, L - 1)) : 0;
      frame(5'(lc), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 3), ab, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
